// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with a small controller.
// Computes {cout,sum} = a + b + cin using one full-adder slice, one bit per clock,
// LSB first. Operands are captured on an accepted start; the result registers
// update only when the last bit has been processed.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter is wide enough to hold WIDTH, so it never wraps within one operation.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             bit_sum;
  logic             bit_carry;
  logic             last_bit;

  // Single full-adder slice on the current LSBs, plus last-bit detection.
  always_comb begin
    bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last_bit  = (cnt == CW'(WIDTH - 1));
  end

  // Status outputs decode directly from state so reset clears them immediately.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Controller and datapath: capture on start in IDLE/DONE, shift one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately ignored here: the operation in flight is never restarted.
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {bit_sum, res_sh[WIDTH-1:1]};
          carry  <= bit_carry;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            state <= DONE;
            sum   <= {bit_sum, res_sh[WIDTH-1:1]};
            cout  <= bit_carry;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed vector table,
// hand-written multi-cycle sequences, and randomized operations against an
// arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks;
  int failures;

  // Last completed result, expected to be held on sum/cout.
  logic [WIDTH-1:0] held_sum;
  logic             held_cout;

  typedef struct {
    string          nm;
    logic [7:0]     va;
    logic [7:0]     vb;
    logic           vc;
    logic [7:0]     es;
    logic           ec;
  } vec_t;

  vec_t vecs[11];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Called #1 after a rising edge. Presents an operation with start, optionally
  // keeps start high for 'hold' RUN cycles and scrambles a/b/cin during RUN,
  // then checks busy/done timing, result and latency.
  task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic [7:0] es, input logic ec,
                        input int hold, input bit scramble);
    int cyc;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    @(posedge clk); #1;
    start = (hold > 0);
    cyc   = 0;
    while (!done && cyc < WIDTH + 4) begin
      chk({nm, " busy"}, 32'(busy), 32'd1);
      chk({nm, " sum_hold"}, 32'(sum), 32'(held_sum));
      chk({nm, " cout_hold"}, 32'(cout), 32'(held_cout));
      if (scramble) begin
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
      end
      cyc++;
      if (cyc >= hold) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, " latency"}, 32'(cyc), 32'(WIDTH));
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " busy_in_done"}, 32'(busy), 32'd0);
    chk({nm, " sum"}, 32'(sum), 32'(es));
    chk({nm, " cout"}, 32'(cout), 32'(ec));
    held_sum  = es;
    held_cout = ec;
  endtask

  initial begin
    logic [8:0] model;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int         gap;

    checks    = 0;
    failures  = 0;
    held_sum  = '0;
    held_cout = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    rst_n     = 1'b0;

    // Directed table: V1, V2, V6 (full-adder truth table on bit 0).
    vecs[0]  = '{"V1_zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{"V2_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{"V2_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3]  = '{"V6_000",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{"V6_001",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5]  = '{"V6_010",   8'h00, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[6]  = '{"V6_011",   8'h00, 8'h01, 1'b1, 8'h02, 1'b0};
    vecs[7]  = '{"V6_100",   8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[8]  = '{"V6_101",   8'h01, 8'h00, 1'b1, 8'h02, 1'b0};
    vecs[9]  = '{"V6_110",   8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[10] = '{"V6_111",   8'h01, 8'h01, 1'b1, 8'h03, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle busy", 32'(busy), 32'd0);

    // Table-driven vectors with one idle cycle between operations.
    foreach (vecs[i]) begin
      run_op(vecs[i].nm, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, 0, 1'b0);
      $display("vec %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", vecs[i].nm,
               vecs[i].va, vecs[i].vb, vecs[i].vc, sum, cout);
      @(posedge clk); #1;
      chk({vecs[i].nm, " done_one_cycle"}, 32'(done), 32'd0);
    end

    // V3: start held high and inputs scrambled during RUN -> single, unaffected result.
    run_op("V3", 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 5, 1'b1);
    $display("V3 sum=%02h cout=%0d", sum, cout);
    @(posedge clk); #1;
    chk("V3 no_restart busy", 32'(busy), 32'd0);
    chk("V3 no_restart done", 32'(done), 32'd0);

    // V4: back-to-back, second start presented in the DONE cycle.
    run_op("V4_first", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0);
    run_op("V4_b2b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    $display("V4 sum=%02h cout=%0d", sum, cout);

    // Give V5 a non-zero result to clear.
    @(posedge clk); #1;
    run_op("V5_pre", 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 0, 1'b0);

    // V5: asynchronous reset in the 4th RUN cycle.
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("V5 busy_before_reset", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("V5 busy", 32'(busy), 32'd0);
    chk("V5 done", 32'(done), 32'd0);
    chk("V5 sum", 32'(sum), 32'd0);
    chk("V5 cout", 32'(cout), 32'd0);
    held_sum  = '0;
    held_cout = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("V5 no_done_after_reset", 32'(done), 32'd0);
      chk("V5 idle_after_reset", 32'(busy), 32'd0);
    end
    $display("V5 reset abort sum=%02h cout=%0d", sum, cout);
    run_op("V5_post", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rc    = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      gap   = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(posedge clk); #1;
      end
      run_op("rand", ra, rb, rc, model[7:0], model[8],
             int'($urandom_range(0, 3)), 1'($urandom));
      $display("rand %0d a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", n, ra, rb, rc, sum, cout);
    end

    @(posedge clk); #1;
    chk("final idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  operand A; captured only on an accepted start.
REQ-006 b  input  WIDTH  operand B; captured only on an accepted start.
REQ-007 cin  input  1  carry-in; captured only on an accepted start.
REQ-008 busy  output  1  high while an addition is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse; marks sum and cout as newly valid.
REQ-010 sum  output  WIDTH  result register.
REQ-011 cout  output  1  final carry-out register.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin using a single 1-bit full-adder slice, one bit per clock cycle, LSB first.
REQ-013 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE: start=1 at an edge SHALL be accepted, latch a, b and cin into internal shift and carry registers, clear the bit counter, and enter RUN.
REQ-015 RUN: each edge SHALL process one bit.
- sum bit = a_bit ^ b_bit ^ carry.
- carry = majority(a_bit, b_bit, carry).
- Shift both operand registers right by one; shift the sum bit into the result shift register from the MSB side.
- Increment the bit counter.
REQ-016 RUN SHALL last exactly WIDTH cycles. On the edge that processes bit WIDTH-1:
- enter DONE;
- load the sum output register from the full result shift register;
- load the cout register from the final carry.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE.
- Latency: done is high in the cycle following the WIDTH-th edge after the start-capture edge.
- Example: WIDTH=8 gives 8 edges from capture to done.
REQ-018 DONE: the next edge SHALL return to IDLE, or to RUN if start=1 at that edge. A start in DONE is accepted exactly as in IDLE (back-to-back operation).
REQ-019 busy SHALL be high only in RUN; busy and done SHALL never be high together.
REQ-020 start while in RUN SHALL be ignored: no operand capture, no restart, no change to the count.
REQ-021 Changes on a, b and cin after capture SHALL have no effect on the result in flight.
REQ-022 sum and cout SHALL hold the last completed result through IDLE and through any subsequent RUN, and SHALL update only on the RUN-to-DONE edge.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL not wrap during a legal operation.
REQ-024 The addition is unsigned modulo 2^WIDTH; overflow is reported only via cout.

Reset
REQ-025 rst_n=0 SHALL, asynchronously and regardless of clk:
- force state to IDLE;
- set busy=0, done=0, sum=0 and cout=0;
- clear the operand registers, carry register and counter.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no result update.
REQ-027 After rst_n rises, the first start SHALL be accepted on the first rising edge that samples start=1.

Verification (WIDTH=8)
REQ-028 The bench SHALL cover these directed scenarios:
- V1: a=8'h00, b=8'h00, cin=0, start pulse -> busy high 8 cycles, then done pulse with sum=8'h00, cout=0.
- V2: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- V3: a=8'h5A, b=8'h3C, cin=1, start held high and a/b changed during RUN -> single result sum=8'h97, cout=0; start during RUN produces no restart.
- V4: start asserted in the DONE cycle with a=8'h80, b=8'h80, cin=0 -> the next operation completes 8 edges later with sum=8'h00, cout=1, and no IDLE cycle in between.
- V5: rst_n pulsed low at the 4th RUN cycle -> busy, done, sum and cout drop to 0 immediately, with no done pulse afterward until a new start.
- V6: all 8 combinations of bit0 of a, b and cin with upper bits zero -> sum[0] and sum[1] match the 1-bit full-adder truth table (sum[1] equals the bit-0 carry).
